// File: rtl/llrf_iq_pkg.sv
// Shared definitions for the ADC-side I/Q demodulator.
//  - DEF_* : default widths (ADC sample, LUT address/word, accumulator, window counter)
//  - iq_state_t : demodulator FSM states
//  - iq_stage_t : per-sample pipeline token (sample, valid, last flag)
//  - trig_word() : elaboration-time cos/sin ROM contents
package llrf_iq_pkg;

  localparam int DEF_ADC_W  = 16;
  localparam int DEF_LUT_AW = 10;
  localparam int DEF_LUT_W  = 16;
  localparam int DEF_ACC_W  = 48;
  localparam int DEF_CNT_W  = 16;

  localparam real TWO_PI = 6.283185307179586;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } iq_state_t;

  typedef struct packed {
    logic signed [DEF_ADC_W-1:0] adc;
    logic                        valid;
    logic                        last;
  } iq_stage_t;

  // round(amp * cos|sin(2*pi*k/depth)), rounding half away from zero.
  // Only ever evaluated as a constant while building the ROM.
  function automatic int trig_word(input int k, input int depth, input int amp,
                                   input bit is_sin);
    real ang;
    real v;
    ang = TWO_PI * real'(k) / real'(depth);
    v   = real'(amp) * (is_sin ? $sin(ang) : $cos(ang));
    return (v < 0.0) ? $rtoi(v - 0.5) : $rtoi(v + 0.5);
  endfunction

endpackage

// File: rtl/iq_trig_lut.sv
// Registered cos/sin ROM for the I/Q demodulator.
//  clk, reset : clock, asynchronous active-high reset (clears the output registers)
//  addr_i     : AW-bit phase address (top bits of the sample phase)
//  cos_o      : round(AMP*cos(2*pi*addr/2^AW)), W-bit signed, one cycle after addr_i
//  sin_o      : round(AMP*sin(2*pi*addr/2^AW)), W-bit signed, one cycle after addr_i
// AMP is 2^(W-1)-1 so both +1.0 and -1.0 are representable.
module iq_trig_lut
  import llrf_iq_pkg::*;
#(
  parameter int AW = DEF_LUT_AW,
  parameter int W  = DEF_LUT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AW-1:0]       addr_i,
  output logic signed [W-1:0] cos_o,
  output logic signed [W-1:0] sin_o
);

  localparam int DEPTH = 1 << AW;
  localparam int AMP   = (1 << (W - 1)) - 1;

  logic signed [W-1:0] cos_rom [DEPTH];
  logic signed [W-1:0] sin_rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int COS_V = trig_word(k, DEPTH, AMP, 1'b0);
    localparam int SIN_V = trig_word(k, DEPTH, AMP, 1'b1);
    assign cos_rom[k] = W'(COS_V);
    assign sin_rom[k] = W'(SIN_V);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cos_o <= '0;
      sin_o <= '0;
    end else begin
      cos_o <= cos_rom[addr_i];
      sin_o <= sin_rom[addr_i];
    end
  end

endmodule

// File: rtl/adc_iq_demod.sv
// Coherent I/Q demodulator: multiplies each accepted ADC sample by cos/sin of
// (ref_phase + phase_offset) and sums the products over an N-sample window.
//  clk, reset    : clock, asynchronous active-high reset
//  start         : one-cycle window request, honoured in IDLE only
//  n_samples     : window length, captured on the accepted start (0 = empty window)
//  phase_offset  : added to ref_phase per sample, captured on the accepted start
//  ref_phase     : DDS phase accumulator value
//  adc_data      : signed ADC sample; adc_valid qualifies adc_data/ref_phase
//  busy          : high from the cycle after the accepted start until out_valid
//  i_out, q_out  : signed sum(adc*cos), sum(adc*sin); held between windows
//  out_valid     : one-cycle pulse when i_out/q_out update
//  state_dbg     : current FSM state (iq_state_t encoding)
// Handshake: a sample is consumed on every RUN cycle with adc_valid=1; there is
// no back-pressure, gaps simply skip. Result latency is 4 cycles from the cycle
// carrying the last sample to the out_valid cycle (S0, S1, S2, S3).
// ADC and LUT word widths are fixed by llrf_iq_pkg (the stage struct carries the sample).
module adc_iq_demod
  import llrf_iq_pkg::*;
#(
  parameter int LUT_AW = DEF_LUT_AW,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_W-1:0]     n_samples,
  input  logic [31:0]          phase_offset,
  input  logic [31:0]          ref_phase,
  input  logic [DEF_ADC_W-1:0] adc_data,
  input  logic                 adc_valid,
  output logic                 busy,
  output logic [ACC_W-1:0]     i_out,
  output logic [ACC_W-1:0]     q_out,
  output logic                 out_valid,
  output logic [1:0]           state_dbg
);

  localparam int PROD_W = DEF_ADC_W + DEF_LUT_W;
  localparam int EXT_W  = ACC_W - PROD_W;
  localparam int LO_W   = 32 - LUT_AW;

  iq_state_t state_q, state_d;

  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      off_q;

  logic start_ok, zero_win, accept, last_s;

  // Pipeline registers
  iq_stage_t                  s0_q, s1_q;
  logic [LUT_AW-1:0]          ph_q;
  logic signed [DEF_LUT_W-1:0] lut_cos, lut_sin;
  logic signed [PROD_W-1:0]   p_i_q, p_q_q;
  logic                       s2_valid_q, s2_last_q;

  logic [ACC_W-1:0] acc_i_q, acc_q_q;
  logic [ACC_W-1:0] i_sum, q_sum;
  logic [ACC_W-1:0] i_out_q, q_out_q;
  logic             out_valid_q;

  // Phase adder: only the LUT address bits are kept. The carry out of the
  // discarded low bits is a + b >= 2^LO_W, i.e. a > ~b.
  logic              ph_carry;
  logic [LUT_AW-1:0] ph_hi;

  assign ph_carry = ref_phase[LO_W-1:0] > ~off_q[LO_W-1:0];
  assign ph_hi    = ref_phase[31:LO_W] + off_q[31:LO_W]
                  + {{(LUT_AW-1){1'b0}}, ph_carry};

  assign start_ok = start && (state_q == IDLE);
  assign zero_win = start_ok && (n_samples == '0);
  assign accept   = (state_q == RUN) && adc_valid;
  assign last_s   = accept && (cnt_q == n_q - CNT_W'(1));

  // FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && n_samples != '0) state_d = RUN;
      RUN:     if (last_s)                   state_d = DRAIN;
      DRAIN:   if (s2_valid_q && s2_last_q)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window parameters and accepted-sample counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q   <= '0;
      off_q <= '0;
      cnt_q <= '0;
    end else if (start_ok) begin
      n_q   <= n_samples;
      off_q <= phase_offset;
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // S0: phase sum, sample and flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_q <= '0;
      ph_q <= '0;
    end else begin
      s0_q.adc   <= adc_data;
      s0_q.valid <= accept;
      s0_q.last  <= last_s;
      ph_q       <= ph_hi;
    end
  end

  // S1: LUT read (registered inside the ROM), token delayed alongside
  iq_trig_lut #(
    .AW (LUT_AW),
    .W  (DEF_LUT_W)
  ) u_lut (
    .clk    (clk),
    .reset  (reset),
    .addr_i (ph_q),
    .cos_o  (lut_cos),
    .sin_o  (lut_sin)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) s1_q <= '0;
    else       s1_q <= s0_q;
  end

  // S2: full-width signed products
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_i_q      <= '0;
      p_q_q      <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      p_i_q      <= $signed(s1_q.adc) * lut_cos;
      p_q_q      <= $signed(s1_q.adc) * lut_sin;
      s2_valid_q <= s1_q.valid;
      s2_last_q  <= s1_q.last;
    end
  end

  // S3: accumulate (wraps modulo 2^ACC_W) and publish on the last sample
  assign i_sum = acc_i_q + {{EXT_W{p_i_q[PROD_W-1]}}, p_i_q};
  assign q_sum = acc_q_q + {{EXT_W{p_q_q[PROD_W-1]}}, p_q_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
    end else if (start_ok) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
    end else if (s2_valid_q) begin
      acc_i_q <= i_sum;
      acc_q_q <= q_sum;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_out_q     <= '0;
      q_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (s2_valid_q && s2_last_q) begin
      i_out_q     <= i_sum;
      q_out_q     <= q_sum;
      out_valid_q <= 1'b1;
    end else if (zero_win) begin
      // An empty window completes immediately with zero sums.
      i_out_q     <= '0;
      q_out_q     <= '0;
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign busy      = (state_q != IDLE);
  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign out_valid = out_valid_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_adc_iq_demod.sv
module tb_adc_iq_demod;

  // Clock / reset and DUT signals
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] n_samples = '0;
  logic [31:0] phase_offset = '0;
  logic [31:0] ref_phase = '0;
  logic [15:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        busy;
  logic [47:0] i_out;
  logic [47:0] q_out;
  logic        out_valid;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  adc_iq_demod dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .n_samples    (n_samples),
    .phase_offset (phase_offset),
    .ref_phase    (ref_phase),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .busy         (busy),
    .i_out        (i_out),
    .q_out        (q_out),
    .out_valid    (out_valid),
    .state_dbg    (state_dbg)
  );

  // Scoreboard state
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          out_cyc = 0;
  logic [47:0] exp_i_q[$];
  logic [47:0] exp_q_q[$];
  logic [47:0] last_i = '0;
  logic [47:0] last_q = '0;
  int          cos_tab[1024];
  int          sin_tab[1024];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, $signed(got), $signed(want));
    end
  endtask

  // Monitor: pops the expected queue on every result pulse
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      out_cyc = cyc;
      last_i  = i_out;
      last_q  = q_out;
      if (exp_i_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got out_valid=1 want no result");
      end else begin
        check("i_out", i_out, exp_i_q.pop_front());
        check("q_out", q_out, exp_q_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input longint ei, input longint eq);
    exp_i_q.push_back(48'(ei));
    exp_q_q.push_back(48'(eq));
  endtask

  task automatic start_win(input logic [15:0] n, input logic [31:0] off);
    start        = 1'b1;
    n_samples    = n;
    phase_offset = off;
    tick();
    start        = 1'b0;
    // Window parameters must have been captured; scramble them now.
    n_samples    = 16'($urandom_range(1, 9));
    phase_offset = $urandom;
  endtask

  task automatic send(input logic [15:0] adc, input logic [31:0] ph, input logic v);
    adc_data  = adc;
    ref_phase = ph;
    adc_valid = v;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (exp_i_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_i_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no out_valid want result within 200 cycles", name);
      exp_i_q.delete();
      exp_q_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     drive_cyc;
    int     nvalid;
    int     a;
    int     idx;
    logic [31:0] ph;
    longint mi;
    longint mq;
    real    qv;
    real    iv;
    real    ref_q;

    for (int k = 0; k < 1024; k++) begin
      cos_tab[k] = int'($floor(32767.0 * $cos(6.283185307179586 * k / 1024.0) + 0.5));
      sin_tab[k] = int'($floor(32767.0 * $sin(6.283185307179586 * k / 1024.0) + 0.5));
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 48'(busy), 48'd0);
    check("reset_out_valid", 48'(out_valid), 48'd0);
    check("reset_i_out", i_out, 48'd0);
    check("reset_q_out", q_out, 48'd0);
    check("reset_state", 48'(state_dbg), 48'd0);
    reset = 1'b0;
    tick();

    // Constant input at zero phase; extra samples past N are ignored
    expect_res(131068000, 0);
    start_win(16'd4, 32'h0);
    check("t1_busy", 48'(busy), 48'd1);
    for (int s = 0; s < 6; s++) send(16'd1000, 32'h0, 1'b1);
    wait_done("t1");
    check("t1_busy_low", 48'(busy), 48'd0);

    // 90 degree offset
    expect_res(0, 131068000);
    start_win(16'd4, 32'h4000_0000);
    for (int s = 0; s < 4; s++) send(16'd1000, 32'h0, 1'b1);
    wait_done("t2");

    // Carry from the low phase bits into the LUT address: 0x003FFFFF + 1 -> index 1
    expect_res(65532000, 402000);
    start_win(16'd2, 32'h0000_0001);
    for (int s = 0; s < 2; s++) send(16'd1000, 32'h003F_FFFF, 1'b1);
    wait_done("t_carry");

    // adc_valid toggling, latency from the 4th valid sample
    expect_res(131068000, 0);
    start_win(16'd4, 32'h0);
    nvalid = 0;
    drive_cyc = 0;
    for (int s = 0; s < 8; s++) begin
      if (s % 2 == 0) begin
        nvalid++;
        if (nvalid == 4) drive_cyc = cyc;
      end
      send(16'd1000, 32'h0, (s % 2 == 0));
    end
    wait_done("t3");
    check("t3_latency", 48'(out_cyc - drive_cyc), 48'd4);

    // Start while busy is ignored
    expect_res(131068000, 0);
    start_win(16'd4, 32'h0);
    send(16'd1000, 32'h0, 1'b1);
    start        = 1'b1;
    n_samples    = 16'd1;
    phase_offset = 32'h4000_0000;
    send(16'd1000, 32'h0, 1'b1);
    start        = 1'b0;
    send(16'd1000, 32'h0, 1'b1);
    send(16'd1000, 32'h0, 1'b1);
    wait_done("t4_busy_start");

    // Empty window
    expect_res(0, 0);
    start_win(16'd0, 32'h0);
    check("t4_n0_busy", 48'(busy), 48'd0);
    wait_done("t4_n0");

    // Live DDS, adc = DDS sine, compared against a bit-true model
    ph = 32'h0;
    mi = 0;
    mq = 0;
    start_win(16'd1000, 32'h0);
    for (int s = 0; s < 1000; s++) begin
      idx = int'(ph[31:22]);
      a   = sin_tab[idx];
      mi += longint'(a * cos_tab[idx]);
      mq += longint'(a * sin_tab[idx]);
      send(16'(a), ph, 1'b1);
      ph = ph + 32'h0147_AEB8;
    end
    expect_res(mi, mq);
    wait_done("t6");
    ref_q = 0.5 * 1000.0 * 32767.0 * 32767.0;
    qv = real'($signed(last_q));
    iv = real'($signed(last_i));
    total++;
    if ((qv - ref_q > 0.001 * ref_q) || (ref_q - qv > 0.001 * ref_q)) begin
      bad++;
      $display("FAIL t6_q_tolerance: got %0d want %0d +-0.1%%", $signed(last_q), longint'(ref_q));
    end
    total++;
    if ((iv > 0.001 * ref_q) || (-iv > 0.001 * ref_q)) begin
      bad++;
      $display("FAIL t6_i_tolerance: got %0d want |i| < %0d", $signed(last_i), longint'(0.001 * ref_q));
    end

    // Reset in the middle of a window
    start_win(16'd4, 32'h0);
    send(16'd1000, 32'h0, 1'b1);
    send(16'd1000, 32'h0, 1'b1);
    reset = 1'b1;
    #2;
    check("t5_busy", 48'(busy), 48'd0);
    check("t5_i_out", i_out, 48'd0);
    check("t5_q_out", q_out, 48'd0);
    check("t5_out_valid", 48'(out_valid), 48'd0);
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    expect_res(-49150500, 0);
    start_win(16'd3, 32'h0);
    for (int s = 0; s < 3; s++) send(16'hFE0C, 32'h0, 1'b1);
    wait_done("t5_clean");

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
